// File: rtl/adc_fill_burst_sequencer_if.sv
// Handshake and configuration bundle between trigger handling, the fill burst
// sequencer and ADC burst capture.
interface adc_fill_burst_sequencer_if #(
    parameter int NUM_TYPES   = 4,
    parameter int TYPE_W      = 2,
    parameter int BURST_CNT_W = 24
);
    logic                             enable;
    logic [TYPE_W-1:0]                fill_type;
    logic [NUM_TYPES*BURST_CNT_W-1:0] num_bursts_cfg;
    logic                             trig;
    logic                             abort;
    logic                             burst_ack;
    logic [BURST_CNT_W-1:0]           num_fill_bursts;
    logic                             burst_req;
    logic [BURST_CNT_W-1:0]           burst_idx;
    logic                             busy;
    logic                             fill_done;
    logic                             fill_aborted;
    logic                             trig_overrun;

    modport master (
        output enable, fill_type, num_bursts_cfg, trig, abort, burst_ack,
        input  num_fill_bursts, burst_req, burst_idx, busy,
               fill_done, fill_aborted, trig_overrun
    );

    modport slave (
        input  enable, fill_type, num_bursts_cfg, trig, abort, burst_ack,
        output num_fill_bursts, burst_req, burst_idx, busy,
               fill_done, fill_aborted, trig_overrun
    );
endinterface

// File: rtl/adc_fill_burst_sequencer.sv
// Latches a fill type's burst count on trigger and issues one valid/ack burst
// request per ADC burst, flagging completion, abort and trigger overrun.
module adc_fill_burst_sequencer #(
    parameter int NUM_TYPES   = 4,
    parameter int TYPE_W      = 2,
    parameter int BURST_CNT_W = 24,
    parameter int NULL_TYPE0  = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    adc_fill_burst_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [BURST_CNT_W-1:0] ONE = BURST_CNT_W'(1);

    logic [1:0]             state;
    logic [BURST_CNT_W-1:0] sel_cnt;
    logic [BURST_CNT_W-1:0] cnt_q;
    logic [BURST_CNT_W-1:0] idx_q;
    logic                   req_q;
    logic                   done_q;
    logic                   abt_q;
    logic                   ovr_q;

    // Types with no slot fall through to a zero count.
    always_comb begin
        sel_cnt = '0;
        for (int k = 0; k < NUM_TYPES; k++) begin
            if (bus.fill_type == TYPE_W'(k))
                sel_cnt = bus.num_bursts_cfg[k*BURST_CNT_W +: BURST_CNT_W];
        end
        if (NULL_TYPE0 != 0 && bus.fill_type == '0)
            sel_cnt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt_q  <= '0;
            idx_q  <= '0;
            req_q  <= 1'b0;
            done_q <= 1'b0;
            abt_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            abt_q  <= 1'b0;
            ovr_q  <= 1'b0;
            // Abort wins over ack and over a colliding trigger.
            if (state != S_IDLE && bus.abort) begin
                state <= S_IDLE;
                req_q <= 1'b0;
                abt_q <= 1'b1;
            end else begin
                if (state != S_IDLE && bus.trig)
                    ovr_q <= 1'b1;
                case (state)
                    S_IDLE: begin
                        if (bus.trig && bus.enable) begin
                            cnt_q <= sel_cnt;
                            idx_q <= '0;
                            state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (cnt_q == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            req_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (req_q && bus.burst_ack) begin
                            // Terminal compare before increment keeps idx from wrapping.
                            if (idx_q == cnt_q - ONE) begin
                                req_q  <= 1'b0;
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + ONE;
                            end
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.num_fill_bursts = cnt_q;
    assign bus.burst_req       = req_q;
    assign bus.burst_idx       = idx_q;
    assign bus.busy            = (state != S_IDLE);
    assign bus.fill_done       = done_q;
    assign bus.fill_aborted    = abt_q;
    assign bus.trig_overrun    = ovr_q;
endmodule

// File: tb/tb_adc_fill_burst_sequencer.sv
// Scoreboard bench: stimulus queues expected burst/done/abort/overrun events,
// a negedge monitor pops and compares them as the sequencer produces them.
module tb_adc_fill_burst_sequencer;
    localparam int NT = 4;
    localparam int TW = 2;
    localparam int W  = 24;

    typedef enum logic [1:0] {K_BURST, K_DONE, K_ABORT, K_OVR} kind_t;
    typedef struct packed {
        kind_t        kind;
        logic [W-1:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    adc_fill_burst_sequencer_if #(.NUM_TYPES(NT), .TYPE_W(TW), .BURST_CNT_W(W)) bus();

    adc_fill_burst_sequencer #(
        .NUM_TYPES(NT), .TYPE_W(TW), .BURST_CNT_W(W), .NULL_TYPE0(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input kind_t k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = W'(v);
        exp_q.push_back(e);
    endtask

    task automatic observe(input kind_t k, input logic [W-1:0] v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d val %0d, expected none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                n_fail++;
                $display("FAIL event: got kind %0d val %0d, expected kind %0d val %0d",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.burst_req && bus.burst_ack && !bus.abort) observe(K_BURST, bus.burst_idx);
            if (bus.fill_done)    observe(K_DONE, bus.num_fill_bursts);
            if (bus.fill_aborted) observe(K_ABORT, '0);
            if (bus.trig_overrun) observe(K_OVR, '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input int v);
        bus.num_bursts_cfg[k*W +: W] = W'(v);
    endtask

    task automatic pulse_trig(input int t);
        bus.fill_type = TW'(t);
        bus.trig      = 1'b1;
        tick();
        bus.trig      = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.num_fill_bursts, bus.burst_req, bus.burst_idx, bus.busy,
                    bus.fill_done, bus.fill_aborted, bus.trig_overrun});
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable         = 1'b1;
        bus.fill_type      = '0;
        bus.num_bursts_cfg = '0;
        bus.trig           = 1'b0;
        bus.abort          = 1'b0;
        bus.burst_ack      = 1'b0;

        // Reset
        repeat (2) tick();
        check("reset_outs", all_outs(), 64'd0);
        rst_n = 1'b1;
        tick();
        check("reset_busy", 64'(bus.busy), 64'd0);

        // Normal fill, ack tied high
        set_slot(1, 3);
        bus.burst_ack = 1'b1;
        push(K_BURST, 0); push(K_BURST, 1); push(K_BURST, 2); push(K_DONE, 3);
        pulse_trig(1);
        @(negedge clk);
        check("t2_nfb", 64'(bus.num_fill_bursts), 64'd3);
        check("t2_load_noreq", 64'(bus.burst_req), 64'd0);
        tick();
        @(negedge clk);
        check("t2_req_latency", 64'(bus.burst_req), 64'd1);
        repeat (5) tick();
        bus.burst_ack = 1'b0;
        check("t2_idle", 64'(bus.busy), 64'd0);
        check("t2_idx_hold", 64'(bus.burst_idx), 64'd2);

        // Null fill, then trig in DONE (overrun) and in re-entered IDLE (accepted)
        set_slot(0, 5);
        push(K_DONE, 0); push(K_OVR, 0); push(K_DONE, 0);
        pulse_trig(0);
        @(negedge clk);
        check("t3_nfb", 64'(bus.num_fill_bursts), 64'd0);
        check("t3_noreq", 64'(bus.burst_req), 64'd0);
        tick();
        check("t3_done_cycle3", 64'(bus.fill_done), 64'd1);
        bus.trig = 1'b1;
        tick();
        tick();
        bus.trig = 1'b0;
        check("t3_reaccept", 64'(bus.busy), 64'd1);
        repeat (3) tick();

        // Stalled ack, overrun mid-RUN, config change mid-fill
        set_slot(2, 2);
        push(K_OVR, 0); push(K_BURST, 0); push(K_BURST, 1); push(K_DONE, 2);
        pulse_trig(2);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                bus.trig = 1'b1;
                set_slot(2, 9);
            end
            if (i == 2) bus.trig = 1'b0;
            @(negedge clk);
            check("t4_stall_req", 64'(bus.burst_req), 64'd1);
            check("t4_stall_idx", 64'(bus.burst_idx), 64'd0);
            tick();
        end
        bus.burst_ack = 1'b1;
        repeat (3) tick();
        bus.burst_ack = 1'b0;
        check("t4_nfb_kept", 64'(bus.num_fill_bursts), 64'd2);

        // Abort together with ack at idx 4, then a fresh fill
        set_slot(3, 10);
        bus.burst_ack = 1'b1;
        push(K_BURST, 0); push(K_BURST, 1); push(K_BURST, 2); push(K_BURST, 3);
        push(K_ABORT, 0);
        pulse_trig(3);
        tick();
        repeat (4) tick();
        check("t5_idx_at_abort", 64'(bus.burst_idx), 64'd4);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t5_abort_idle", 64'(bus.busy), 64'd0);
        check("t5_abort_noreq", 64'(bus.burst_req), 64'd0);
        check("t5_aborted", 64'(bus.fill_aborted), 64'd1);
        set_slot(3, 1);
        push(K_BURST, 0); push(K_DONE, 1);
        pulse_trig(3);
        tick();
        check("t5_restart_idx", 64'(bus.burst_idx), 64'd0);
        check("t5_restart_req", 64'(bus.burst_req), 64'd1);
        repeat (3) tick();
        bus.burst_ack = 1'b0;

        // Async reset mid-RUN, then trig with enable low
        set_slot(1, 3);
        pulse_trig(1);
        tick();
        tick();
        check("t6_running", 64'(bus.burst_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_reset", all_outs(), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.enable = 1'b0;
        pulse_trig(1);
        repeat (3) tick();
        check("t6_enable_gate", 64'(bus.busy), 64'd0);
        check("t6_enable_nfb", 64'(bus.num_fill_bursts), 64'd0);
        bus.enable = 1'b1;

        repeat (2) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
